gmii_rx_fcs_chk: RTL and testbench
==================================

# gmii_rx_fcs_chk

Receive-side GMII frame checker: strips preamble/SFD, streams frame bytes with the 4-byte FCS removed, and validates the FCS and minimum length. It is the receive-side counterpart of the transmit path's CRC32 FCS insertion. It sits between the PHY receive pins and the UDP/ARP receive parsers, so those parsers only ever see good or flagged frames.

## Interface
- `MIN_LEN`, 64: minimum frame length in bytes, FCS included; shorter frames are runts and flagged bad.
- `clk` in 1: GMII receive clock (gmii_rxc domain); single clock.
- `rst` in 1: synchronous, active-high reset.
- `gmii_rxdv` in 1: receive data valid.
- `gmii_rxd` in 8: receive byte.
- `out_valid` out 1: `out_data` is valid this cycle.
- `out_data` out 8: frame byte (DA onward, FCS excluded).
- `out_sof` out 1: qualifies the first `out_valid` byte of a frame.
- `frame_done` out 1: one-cycle pulse at frame end.
- `frame_good` out 1: valid with `frame_done`; FCS ok and length ≥ `MIN_LEN`.
- `frame_len` out 16: valid with `frame_done`; byte count excluding FCS, saturating at 0xFFFF.
- `good_cnt` out 16: saturating count of good frames (see Configuration).
- `bad_cnt` out 16: saturating count of bad frames (see Configuration).

## Operation
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rxdv=1, rxd=0x55 → PREAMBLE.
  - rxdv=1, any other byte → DROP.
- PREAMBLE:
  - 0x55 → stay.
  - 0xD5 → DATA; CRC register loads 0xFFFFFFFF; byte counter cleared.
  - Any other byte → DROP.
  - rxdv=0 → IDLE, no `frame_done`.
- DATA:
  - Each byte updates the CRC: reflected polynomial 0x04C11DB7 (LSB-first), no final XOR.
  - Each byte shifts into a 4-byte delay line and increments a 16-bit saturating counter.
  - Once the delay line is full, each new byte pushes out the oldest byte as `out_data` with `out_valid`. The first byte pushed out also carries `out_sof`.
  - rxdv=0 → IDLE and `frame_done` pulses.
  - `frame_good` = (CRC register == 0xDEBB20E3) && (count ≥ `MIN_LEN`).
  - `frame_len` = count−4, or 0 if count < 4.
  - The delay-line contents (the FCS) are discarded, never output.
- DROP: ignore bytes until rxdv=0 → IDLE; no `frame_done`, no counters change.
- No preamble-length check: a lone SFD after one 0x55 is accepted.
- Consumers must discard data on `frame_done` with `frame_good`=0; the block cannot retract bytes already streamed.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, FSM IDLE, CRC 0xFFFFFFFF, delay line 0.
- Latency: DATA byte n (0-based) sampled in cycle t appears on `out_data` in cycle t+1 of the cycle in which byte n+4 is sampled; i.e. 4 byte-times plus 1 register stage.
- `frame_done` asserts the cycle after rxdv is first sampled low in DATA. It never coincides with `out_valid`.
- Back-to-back frames: a 1-cycle rxdv-low gap is sufficient. IDLE accepts 0x55 in the cycle after `frame_done`'s triggering sample.
- rxdv low for a single cycle mid-DATA ends the frame; a subsequent high is treated as a new frame.
- Reset asserted mid-frame: everything clears and no `frame_done` is produced. If rxdv is still high after reset with non-0x55 data, the FSM goes to DROP.
- Counter saturation: `frame_len` and the counters hold at 0xFFFF.

## Configuration
- `GMII_RX_STATS_EN` defined:
  - `good_cnt` increments on `frame_done` with `frame_good`=1.
  - `bad_cnt` increments on `frame_done` with `frame_good`=0.
  - Both are 16-bit saturating, update the cycle after `frame_done`, and clear only on `rst`.
- Not defined: `good_cnt`/`bad_cnt` are tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package `eth_pkg` holds:
  - FSM state enum.
  - Constants `ETH_PREAMBLE`=8'h55, `ETH_SFD`=8'hD5, `CRC32_INIT`=32'hFFFFFFFF, `CRC32_RESIDUE`=32'hDEBB20E3.
  - Function `crc32_d8(crc, byte)`: reflected byte update.
- No sub-module; the delay line, FSM and counters stay inline. The shared function keeps the CRC consistent with the transmit side.

## Test plan
- Good frame: 7×0x55, 0xD5, 60 data bytes 0x00..0x3B, correct FCS → 60 `out_valid` bytes 0x00..0x3B, first with `out_sof`; `frame_done` with `frame_good`=1, `frame_len`=60; `good_cnt`=1.
- Same frame with data byte 10 flipped to 0xFF → same 60-byte stream with byte 10 = 0xFF; `frame_good`=0; `bad_cnt`=1.
- Runt: 40 data bytes + valid FCS → 40 bytes streamed; `frame_good`=0, `frame_len`=40.
- Bad preamble 0x55,0x55,0x12,… → no `out_valid`, no `frame_done`; a following good frame is accepted normally.
- Two good 64-byte frames separated by a 1-cycle rxdv gap → two `frame_done` pulses, both good; `out_sof` fires twice.
- `rst` asserted for 1 cycle at data byte 20, rxdv stays high → no `frame_done`, all outputs 0, FSM in DROP; the next frame is checked good.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: rx FSM states, framing constants and CRC32.
// The byte-wise CRC update is shared with the transmit FCS inserter.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;

  // Reflected 0x04C11DB7, LSB first, no final XOR.
  function automatic logic [31:0] crc32_d8(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_rx_fcs_chk.sv
// GMII receive frame checker: strips preamble/SFD, hides the FCS, flags bad frames.
// Define GMII_RX_STATS_EN to build the good/bad frame counters.
module gmii_rx_fcs_chk
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rxdv,
  input  logic [7:0]  gmii_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_good,
  output logic [15:0] frame_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

  rx_state_e        state;
  logic [31:0]      crc;
  logic [3:0][7:0]  dly;
  logic [15:0]      cnt;
  logic [15:0]      cnt_inc;
  logic [15:0]      len_calc;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Once the byte count has saturated the length stays pinned at 0xFFFF.
  always_comb begin
    len_calc = 16'h0;
    if (cnt == 16'hFFFF) len_calc = 16'hFFFF;
    else if (cnt >= 16'd4) len_calc = cnt - 16'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      crc        <= CRC32_INIT;
      dly        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      frame_len  <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (gmii_rxdv) begin
            state <= (gmii_rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rxdv) begin
            state <= ST_IDLE;
          end else if (gmii_rxd == ETH_SFD) begin
            state <= ST_DATA;
            crc   <= CRC32_INIT;
            cnt   <= '0;
          end else if (gmii_rxd != ETH_PREAMBLE) begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (gmii_rxdv) begin
            crc <= crc32_d8(crc, gmii_rxd);
            dly <= {dly[2:0], gmii_rxd};
            cnt <= cnt_inc;
            // The last four bytes stay in the delay line: they are the FCS.
            if (cnt >= 16'd4) begin
              out_valid <= 1'b1;
              out_data  <= dly[3];
              out_sof   <= (cnt == 16'd4);
            end
          end else begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_good <= (crc == CRC32_RESIDUE) && (cnt >= MIN_LEN_W);
            frame_len  <= len_calc;
          end
        end
        ST_DROP: begin
          if (!gmii_rxdv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GMII_RX_STATS_EN
  logic [15:0] good_q;
  logic [15:0] bad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (frame_done) begin
      if (frame_good && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (!frame_good && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_fcs_chk.sv
// Directed bench for gmii_rx_fcs_chk with a bit-serial reference FCS.
// Builds with or without GMII_RX_STATS_EN.
module tb_gmii_rx_fcs_chk;
  import eth_pkg::*;

`ifdef GMII_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_rxdv;
  logic [7:0]  gmii_rxd;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        frame_done;
  logic        frame_good;
  logic [15:0] frame_len;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_fcs_chk #(.MIN_LEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .gmii_rxdv  (gmii_rxdv),
    .gmii_rxd   (gmii_rxd),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .frame_done (frame_done),
    .frame_good (frame_good),
    .frame_len  (frame_len),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  int          sof_pos[$];
  logic        done_good[$];
  logic [15:0] done_len[$];
  int          overlap = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      if (out_sof) sof_pos.push_back(rx_q.size());
      rx_q.push_back(out_data);
    end else if (out_sof) begin
      overlap++;
    end
    if (frame_done) begin
      done_good.push_back(frame_good);
      done_len.push_back(frame_len);
      if (out_valid) overlap++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Bit-at-a-time reference: init all ones, no final inversion.
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic dv, input logic [7:0] d);
    @(negedge clk);
    gmii_rxdv = dv;
    gmii_rxd  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    sof_pos.delete();
    done_good.delete();
    done_len.delete();
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input logic [31:0] fcs);
    for (int i = 0; i < 7; i++) tick(1'b1, 8'h55);
    tick(1'b1, 8'hD5);
    foreach (pl[k]) tick(1'b1, pl[k]);
    for (int i = 0; i < 4; i++) tick(1'b1, fcs[8*i +: 8]);
    tick(1'b0, 8'h00);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp[$]);
    int mis;
    mis = 0;
    check({tag, "_len"}, rx_q.size(), exp.size());
    foreach (exp[k]) begin
      if (k < rx_q.size() && rx_q[k] !== exp[k]) mis++;
    end
    check({tag, "_bytes"}, mis, 0);
  endtask

  logic [7:0]  pl60[$];
  logic [7:0]  pl_bad[$];
  logic [7:0]  pl40[$];
  logic [7:0]  pl64[$];
  logic [7:0]  ascii[$];
  logic [31:0] fcs60;
  logic [31:0] fcs40;
  logic [31:0] fcs64;
  int          n0;

  initial begin
    rst       = 1'b1;
    gmii_rxdv = 1'b0;
    gmii_rxd  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_good", frame_good, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_good_cnt", good_cnt, 0);
    check("rst_bad_cnt", bad_cnt, 0);
    rst = 1'b0;

    // Reference model sanity: CRC-32 of "123456789" is 0xCBF43926.
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("ref_crc_check", ~ref_crc(ascii), 32'hCBF43926);

    for (int i = 0; i < 60; i++) pl60.push_back(8'(i));
    for (int i = 0; i < 40; i++) pl40.push_back(8'(i));
    for (int i = 0; i < 64; i++) pl64.push_back(8'(i + 8'h80));
    fcs60 = ~ref_crc(pl60);
    fcs40 = ~ref_crc(pl40);
    fcs64 = ~ref_crc(pl64);

    // Good 60-byte frame.
    idle(2);
    clear_mon();
    send_frame(pl60, fcs60);
    idle(4);
    check_stream("good", pl60);
    check("good_sof_n", sof_pos.size(), 1);
    check("good_sof_pos", sof_pos.size() > 0 ? sof_pos[0] : -1, 0);
    check("good_done_n", done_good.size(), 1);
    check("good_flag", done_good.size() > 0 ? done_good[0] : 1'bx, 1);
    check("good_frame_len", done_len.size() > 0 ? done_len[0] : 16'hx, 60);
    check("good_cnt_1", good_cnt, STATS ? 1 : 0);
    check("bad_cnt_0", bad_cnt, 0);

    // Same frame, byte 10 corrupted, original FCS.
    pl_bad = pl60;
    pl_bad[10] = 8'hFF;
    clear_mon();
    send_frame(pl_bad, fcs60);
    idle(4);
    check_stream("corrupt", pl_bad);
    check("corrupt_done_n", done_good.size(), 1);
    check("corrupt_flag", done_good.size() > 0 ? done_good[0] : 1'bx, 0);
    check("corrupt_frame_len", done_len.size() > 0 ? done_len[0] : 16'hx, 60);
    check("corrupt_bad_cnt", bad_cnt, STATS ? 1 : 0);

    // Runt: valid FCS but only 44 bytes on the wire.
    clear_mon();
    send_frame(pl40, fcs40);
    idle(4);
    check_stream("runt", pl40);
    check("runt_flag", done_good.size() > 0 ? done_good[0] : 1'bx, 0);
    check("runt_frame_len", done_len.size() > 0 ? done_len[0] : 16'hx, 40);
    check("runt_bad_cnt", bad_cnt, STATS ? 2 : 0);

    // Bad preamble is dropped entirely, next frame still accepted.
    clear_mon();
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h12);
    tick(1'b1, 8'hD5);
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(i));
    idle(4);
    check("badpre_no_valid", rx_q.size(), 0);
    check("badpre_no_done", done_good.size(), 0);
    send_frame(pl60, fcs60);
    idle(4);
    check_stream("after_badpre", pl60);
    check("after_badpre_flag", done_good.size() > 0 ? done_good[0] : 1'bx, 1);
    check("after_badpre_good_cnt", good_cnt, STATS ? 2 : 0);

    // Back-to-back with a one-cycle rxdv gap.
    clear_mon();
    send_frame(pl64, fcs64);
    send_frame(pl64, fcs64);
    idle(4);
    check("b2b_done_n", done_good.size(), 2);
    check("b2b_good0", done_good.size() > 0 ? done_good[0] : 1'bx, 1);
    check("b2b_good1", done_good.size() > 1 ? done_good[1] : 1'bx, 1);
    check("b2b_len1", done_len.size() > 1 ? done_len[1] : 16'hx, 64);
    check("b2b_sof_n", sof_pos.size(), 2);
    check("b2b_sof_pos1", sof_pos.size() > 1 ? sof_pos[1] : -1, 64);
    check("b2b_bytes", rx_q.size(), 128);
    check("b2b_good_cnt", good_cnt, STATS ? 4 : 0);
    check("no_done_valid_overlap", overlap, 0);

    // Reset pulse at data byte 20 with rxdv held high.
    clear_mon();
    for (int i = 0; i < 7; i++) tick(1'b1, 8'h55);
    tick(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) tick(1'b1, pl60[i]);
    @(negedge clk);
    rst      = 1'b1;
    gmii_rxd = pl60[20];
    @(negedge clk);
    rst      = 1'b0;
    gmii_rxd = pl60[21];
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_frame_len", frame_len, 0);
    check("midrst_good_cnt", good_cnt, 0);
    check("midrst_bad_cnt", bad_cnt, 0);
    n0 = rx_q.size();
    check("midrst_pre_bytes", n0, 16);
    for (int i = 22; i < 60; i++) begin
      tick(1'b1, pl60[i]);
      if (i == 22) check("midrst_state_drop", 32'(dut.state), 32'(ST_DROP));
    end
    for (int i = 0; i < 4; i++) tick(1'b1, fcs60[8*i +: 8]);
    idle(4);
    check("midrst_no_done", done_good.size(), 0);
    check("midrst_no_bytes", rx_q.size(), n0);
    clear_mon();
    send_frame(pl60, fcs60);
    idle(4);
    check_stream("post_rst", pl60);
    check("post_rst_flag", done_good.size() > 0 ? done_good[0] : 1'bx, 1);
    check("post_rst_good_cnt", good_cnt, STATS ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
